// File: rtl/pipe_pkg.sv
// Shared decode constants, the multdiv FSM state type and a mul/div decode helper
// for the pipeline hazard controller.
package pipe_pkg;

   localparam logic [4:0]  OP_RTYPE = 5'b00000;
   localparam logic [4:0]  OP_LW    = 5'b01000;
   localparam logic [4:0]  ALU_MUL  = 5'b00110;
   localparam logic [4:0]  ALU_DIV  = 5'b00111;
   localparam logic [31:0] NOP_WORD = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE,
      START,
      BUSY,
      DONE
   } md_state_t;

   // True when the word is an R-type multiply or divide.
   function automatic logic is_muldiv(input logic [31:0] ir);
      return (ir != NOP_WORD) && (ir[31:27] == OP_RTYPE) &&
             ((ir[6:2] == ALU_MUL) || (ir[6:2] == ALU_DIV));
   endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: a load in D/X whose destination is read
// by the instruction in F/D.
module load_use_detect
   import pipe_pkg::*;
(
   input  logic [31:0] fd_ir_i,
   input  logic [31:0] dx_ir_i,
   output logic        stall_o
);

   logic [4:0] dx_rd;
   logic [4:0] fd_rs;
   logic [4:0] fd_rt;
   logic       unused_bits;

   assign dx_rd = dx_ir_i[26:22];
   assign fd_rs = fd_ir_i[21:17];
   assign fd_rt = fd_ir_i[16:12];

   // r0 is hardwired, so a load into it never creates a dependency.
   assign stall_o = (dx_ir_i[31:27] == OP_LW) && (dx_rd != 5'd0) &&
                    ((dx_rd == fd_rs) || (dx_rd == fd_rt));

   assign unused_bits = ^{fd_ir_i[31:22], fd_ir_i[11:0], dx_ir_i[21:0]};

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: latch enables, bubble inserts, and the multdiv stall handshake.
// Defining HAZARD_PERF_EN adds the stall_cnt_o / flush_cnt_o event counters.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int MD_TIMEOUT = 40
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [31:0] fd_ir_i,
   input  logic [31:0] dx_ir_i,
   input  logic        br_taken_i,
   input  logic        md_ready_i,
   output logic        pc_we_o,
   output logic        fd_we_o,
   output logic        dx_we_o,
   output logic        xm_we_o,
   output logic        mw_we_o,
   output logic        fd_flush_o,
   output logic        dx_flush_o,
   output logic        xm_flush_o,
   output logic        md_mult_o,
   output logic        md_div_o,
   output logic        md_busy_o,
   output logic        md_err_o
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0] stall_cnt_o,
   output logic [31:0] flush_cnt_o
`endif
);

   localparam int CNT_W = $clog2(MD_TIMEOUT + 1);

   md_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             md_err_q, md_err_d;
   logic             op_div_q, op_div_d;
   logic             load_use;
   logic             br_act;

   load_use_detect u_load_use_detect (
      .fd_ir_i (fd_ir_i),
      .dx_ir_i (dx_ir_i),
      .stall_o (load_use)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         md_err_q <= 1'b0;
         op_div_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         md_err_q <= md_err_d;
         op_div_q <= op_div_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      md_err_d   = md_err_q;
      op_div_d   = op_div_q;
      pc_we_o    = 1'b1;
      fd_we_o    = 1'b1;
      dx_we_o    = 1'b1;
      xm_we_o    = 1'b1;
      mw_we_o    = 1'b1;
      fd_flush_o = 1'b0;
      dx_flush_o = 1'b0;
      xm_flush_o = 1'b0;
      md_mult_o  = 1'b0;
      md_div_o   = 1'b0;
      md_busy_o  = 1'b0;
      md_err_o   = md_err_q;
      br_act     = 1'b0;

      unique case (state_q)
         IDLE: begin
            // Freeze the mul/div in D/X on detection so START still sees it.
            if (is_muldiv(dx_ir_i)) begin
               state_d    = START;
               op_div_d   = (dx_ir_i[6:2] == ALU_DIV);
               pc_we_o    = 1'b0;
               fd_we_o    = 1'b0;
               dx_we_o    = 1'b0;
               xm_flush_o = 1'b1;
            end else if (br_taken_i) begin
               fd_flush_o = 1'b1;
               dx_flush_o = 1'b1;
               br_act     = 1'b1;
            end else if (load_use) begin
               pc_we_o    = 1'b0;
               fd_we_o    = 1'b0;
               dx_flush_o = 1'b1;
            end
         end
         START: begin
            md_mult_o  = ~op_div_q;
            md_div_o   = op_div_q;
            pc_we_o    = 1'b0;
            fd_we_o    = 1'b0;
            dx_we_o    = 1'b0;
            xm_flush_o = 1'b1;
            cnt_d      = '0;
            state_d    = BUSY;
         end
         BUSY: begin
            md_busy_o  = 1'b1;
            pc_we_o    = 1'b0;
            fd_we_o    = 1'b0;
            dx_we_o    = 1'b0;
            xm_flush_o = 1'b1;
            cnt_d      = cnt_q + 1'b1;
            if (md_ready_i) begin
               state_d = DONE;
            end else if (cnt_d == CNT_W'(MD_TIMEOUT)) begin
               md_err_d = 1'b1;
               state_d  = DONE;
            end
         end
         DONE: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Reset forces every output low immediately, not at the next edge.
      if (!rst_ni) begin
         pc_we_o    = 1'b0;
         fd_we_o    = 1'b0;
         dx_we_o    = 1'b0;
         xm_we_o    = 1'b0;
         mw_we_o    = 1'b0;
         fd_flush_o = 1'b0;
         dx_flush_o = 1'b0;
         xm_flush_o = 1'b0;
         md_mult_o  = 1'b0;
         md_div_o   = 1'b0;
         md_busy_o  = 1'b0;
         md_err_o   = 1'b0;
         br_act     = 1'b0;
      end
   end

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cnt_q, flush_cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (!pc_we_o) stall_cnt_q <= stall_cnt_q + 32'd1;
         if (br_act)   flush_cnt_q <= flush_cnt_q + 32'd1;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed vector table, hand-written
// multdiv/reset sequences, and randomized cycles against a cycle-count reference model.
module tb_pipe_hazard_ctrl;

   localparam logic [31:0] NOP = 32'h0;

   logic        clk = 1'b0;
   logic        rstN;
   logic [31:0] fdIr, dxIr;
   logic        brTaken, mdReady;
   logic        pcWe, fdWe, dxWe, xmWe, mwWe;
   logic        fdFlush, dxFlush, xmFlush;
   logic        mdMult, mdDiv, mdBusy, mdErr;
`ifdef HAZARD_PERF_EN
   logic [31:0] stallCnt, flushCnt;
`endif

   int vecCount = 0;
   int errCount = 0;

   // Reference model: mdAge = -1 no op, 0 start cycle, 1..40 busy cycle number, -2 done cycle.
   int          mdAge = -1;
   bit          mdIsDiv = 1'b0;
   bit          errM = 1'b0;
   int          stallM = 0;
   int          flushM = 0;
   logic [11:0] lastOut;
   int          pcLow, multPulses;

   typedef struct {
      string       name;
      logic [31:0] fd;
      logic [31:0] dx;
      logic        br;
      logic        rdy;
      logic [11:0] exp;
   } vec_t;

   vec_t tbl[10];

   always #5 clk = ~clk;

   pipe_hazard_ctrl dut (
      .clk_i      (clk),
      .rst_ni     (rstN),
      .fd_ir_i    (fdIr),
      .dx_ir_i    (dxIr),
      .br_taken_i (brTaken),
      .md_ready_i (mdReady),
      .pc_we_o    (pcWe),
      .fd_we_o    (fdWe),
      .dx_we_o    (dxWe),
      .xm_we_o    (xmWe),
      .mw_we_o    (mwWe),
      .fd_flush_o (fdFlush),
      .dx_flush_o (dxFlush),
      .xm_flush_o (xmFlush),
      .md_mult_o  (mdMult),
      .md_div_o   (mdDiv),
      .md_busy_o  (mdBusy),
      .md_err_o   (mdErr)
`ifdef HAZARD_PERF_EN
      ,
      .stall_cnt_o(stallCnt),
      .flush_cnt_o(flushCnt)
`endif
   );

   function automatic logic [31:0] mkR(input logic [4:0] rd, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [4:0] alu);
      return {5'b00000, rd, rs, rt, 5'b00000, alu, 2'b00};
   endfunction

   function automatic logic [31:0] mkLw(input logic [4:0] rd, input logic [4:0] rs);
      return {5'b01000, rd, rs, 17'h00004};
   endfunction

   function automatic bit isMd(input logic [31:0] ir);
      return (ir[31:27] == 5'b00000) && (ir[6:2] == 5'b00110 || ir[6:2] == 5'b00111);
   endfunction

   // Output vector order: {pc,fd,dx,xm,mw, fdFlush,dxFlush,xmFlush, mult,div,busy,err}
   function automatic logic [11:0] actualOut();
      return {pcWe, fdWe, dxWe, xmWe, mwWe, fdFlush, dxFlush, xmFlush,
              mdMult, mdDiv, mdBusy, mdErr};
   endfunction

   function automatic logic [11:0] expected(input logic rn, input logic [31:0] fd,
                                            input logic [31:0] dx, input logic br);
      logic pc, f, d, x, m, ff, df, xf, mu, dv, bz;
      int   rd;
      bit   lu;
      if (!rn) return 12'h000;
      {pc, f, d, x, m} = 5'b11111;
      {ff, df, xf, mu, dv, bz} = 6'b000000;
      rd = int'(dx[26:22]);
      lu = (dx[31:27] == 5'b01000) && (rd != 0) &&
           (rd == int'(fd[21:17]) || rd == int'(fd[16:12]));
      if (mdAge == -1) begin
         if (isMd(dx)) begin
            {pc, f, d} = 3'b000; xf = 1'b1;
         end else if (br) begin
            ff = 1'b1; df = 1'b1;
         end else if (lu) begin
            pc = 1'b0; f = 1'b0; df = 1'b1;
         end
      end else if (mdAge == 0) begin
         {pc, f, d} = 3'b000; xf = 1'b1;
         mu = !mdIsDiv; dv = mdIsDiv;
      end else if (mdAge > 0) begin
         {pc, f, d} = 3'b000; xf = 1'b1; bz = 1'b1;
      end
      return {pc, f, d, x, m, ff, df, xf, mu, dv, bz, errM};
   endfunction

   task automatic modelAdvance(input logic [31:0] fd, input logic [31:0] dx,
                               input logic br, input logic rdy);
      logic [11:0] e;
      e = expected(1'b1, fd, dx, br);
      if (!e[11]) stallM++;
      if (mdAge == -1 && !isMd(dx) && br) flushM++;
      if (mdAge == -1) begin
         if (isMd(dx)) begin
            mdAge = 0;
            mdIsDiv = (dx[6:2] == 5'b00111);
         end
      end else if (mdAge == 0) begin
         mdAge = 1;
      end else if (mdAge > 0) begin
         if (rdy) mdAge = -2;
         else if (mdAge == 40) begin
            errM = 1'b1;
            mdAge = -2;
         end else mdAge++;
      end else begin
         mdAge = -1;
      end
   endtask

   task automatic checkOutput(input string name, input logic [11:0] exp);
      lastOut = actualOut();
      vecCount++;
      if (lastOut !== exp) begin
         errCount++;
         $display("[TB] FAIL %s: outputs got %03h expected %03h (t=%0t)", name, lastOut, exp, $time);
      end
   endtask

   task automatic checkVal(input string name, input int got, input int exp);
      vecCount++;
      if (got != exp) begin
         errCount++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Entered at posedge+1; checks mid-cycle, then clocks the model with the edge.
   task automatic applyStimulus(input logic [31:0] fd, input logic [31:0] dx,
                                input logic br, input logic rdy, input string name);
      fdIr = fd; dxIr = dx; brTaken = br; mdReady = rdy;
      #4;
      checkOutput(name, expected(rstN, fd, dx, br));
      if (!lastOut[11]) pcLow++;
      if (lastOut[3]) multPulses++;
      @(posedge clk);
      modelAdvance(fd, dx, br, rdy);
      #1;
   endtask

   task automatic applyReset(input int n);
      rstN = 1'b0;
      #1;
      checkOutput("reset_async", 12'h000);
      mdAge = -1; errM = 1'b0; mdIsDiv = 1'b0; stallM = 0; flushM = 0;
      repeat (n) begin
         @(posedge clk);
         #1;
         checkOutput("reset_hold", 12'h000);
      end
      rstN = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] mulW, divW, fdR, dxR;
      int          r;
      mulW = mkR(5'd3, 5'd1, 5'd2, 5'b00110);
      divW = mkR(5'd4, 5'd1, 5'd2, 5'b00111);
      fdIr = NOP; dxIr = NOP; brTaken = 1'b0; mdReady = 1'b0;
      rstN = 1'b0;

      tbl[0] = '{"lu_rs",        mkR(5'd1, 5'd5, 5'd2, 5'd0), mkLw(5'd5, 5'd0), 1'b0, 1'b0, 12'h3A0};
      tbl[1] = '{"lu_next",      mkR(5'd1, 5'd5, 5'd2, 5'd0), NOP,               1'b0, 1'b0, 12'hF80};
      tbl[2] = '{"lu_rt",        mkR(5'd3, 5'd2, 5'd7, 5'd0), mkLw(5'd7, 5'd1), 1'b0, 1'b0, 12'h3A0};
      tbl[3] = '{"lu_r0",        mkR(5'd1, 5'd0, 5'd0, 5'd0), mkLw(5'd0, 5'd2), 1'b0, 1'b0, 12'hF80};
      tbl[4] = '{"lu_nomatch",   mkR(5'd5, 5'd6, 5'd7, 5'd0), mkLw(5'd5, 5'd1), 1'b0, 1'b0, 12'hF80};
      tbl[5] = '{"rtype_rd",     mkR(5'd1, 5'd5, 5'd5, 5'd0), mkR(5'd5, 5'd1, 5'd2, 5'd0), 1'b0, 1'b0, 12'hF80};
      tbl[6] = '{"br_over_lu",   mkR(5'd1, 5'd5, 5'd2, 5'd0), mkLw(5'd5, 5'd0), 1'b1, 1'b0, 12'hFE0};
      tbl[7] = '{"br_plain",     NOP,                         NOP,               1'b1, 1'b0, 12'hFE0};
      tbl[8] = '{"ready_idle",   NOP,                         NOP,               1'b0, 1'b1, 12'hF80};
      tbl[9] = '{"lu_ready_ign", mkR(5'd1, 5'd2, 5'd9, 5'd1), mkLw(5'd9, 5'd3), 1'b0, 1'b1, 12'h3A0};

      $display("[TB] reset and release");
      applyReset(3);
      applyStimulus(NOP, NOP, 1'b0, 1'b0, "release_idle");

      $display("[TB] directed vector table");
      for (int i = 0; i < 10; i++) begin
         fdIr = tbl[i].fd; dxIr = tbl[i].dx; brTaken = tbl[i].br; mdReady = tbl[i].rdy;
         #4;
         checkOutput(tbl[i].name, tbl[i].exp);
         @(posedge clk);
         modelAdvance(tbl[i].fd, tbl[i].dx, tbl[i].br, tbl[i].rdy);
         #1;
      end

      $display("[TB] multiply, ready on 17th busy cycle");
      pcLow = 0; multPulses = 0;
      applyStimulus(NOP, mulW, 1'b0, 1'b0, "mul_idle");
      applyStimulus(NOP, mulW, 1'b0, 1'b0, "mul_start");
      for (int k = 1; k <= 17; k++)
         applyStimulus(NOP, mulW, (k == 5), (k == 17), "mul_busy");
      applyStimulus(NOP, mulW, 1'b0, 1'b0, "mul_done");
      checkVal("mul_done_we", int'(lastOut[11:7]), 31);
      checkVal("mul_done_err", int'(lastOut[0]), 0);
      applyStimulus(NOP, NOP, 1'b0, 1'b0, "mul_after");
      checkVal("mul_pc_stall_cycles", pcLow, 19);
      checkVal("mul_pulses", multPulses, 1);

      $display("[TB] ready coincident with timeout");
      applyStimulus(NOP, mulW, 1'b0, 1'b0, "tie_idle");
      applyStimulus(NOP, mulW, 1'b0, 1'b0, "tie_start");
      for (int k = 1; k <= 40; k++)
         applyStimulus(NOP, mulW, 1'b0, (k == 40), "tie_busy");
      applyStimulus(NOP, mulW, 1'b0, 1'b0, "tie_done");
      checkVal("tie_err", int'(lastOut[0]), 0);

      $display("[TB] divide timeout");
      applyStimulus(NOP, NOP, 1'b0, 1'b0, "to_pre");
      applyStimulus(NOP, divW, 1'b0, 1'b0, "to_idle");
      applyStimulus(NOP, divW, 1'b0, 1'b0, "to_start");
      checkVal("to_div_pulse", int'(lastOut[2]), 1);
      for (int k = 1; k <= 40; k++)
         applyStimulus(NOP, divW, 1'b0, 1'b0, "to_busy");
      applyStimulus(NOP, divW, 1'b0, 1'b0, "to_done");
      checkVal("to_err", int'(lastOut[0]), 1);
      applyStimulus(NOP, NOP, 1'b0, 1'b0, "to_idle_after");
      checkVal("to_err_sticky", int'(lastOut[0]), 1);

      $display("[TB] reset during busy");
      applyStimulus(NOP, divW, 1'b0, 1'b0, "rb_idle");
      applyStimulus(NOP, divW, 1'b0, 1'b0, "rb_start");
      for (int k = 1; k <= 5; k++)
         applyStimulus(NOP, divW, 1'b0, 1'b0, "rb_busy");
      dxIr = mulW;
      applyReset(2);
      applyStimulus(NOP, mulW, 1'b0, 1'b0, "rb_reeval");
      checkVal("rb_no_reissue", int'(lastOut[3]), 0);
      applyStimulus(NOP, mulW, 1'b0, 1'b0, "rb_restart");
      checkVal("rb_restart_pulse", int'(lastOut[3]), 1);
      for (int k = 1; k <= 40; k++)
         applyStimulus(NOP, mulW, 1'b0, 1'b0, "rb_busy_full");
      applyStimulus(NOP, mulW, 1'b0, 1'b0, "rb_done");
      checkVal("rb_full_timeout_err", int'(lastOut[0]), 1);
      applyStimulus(NOP, NOP, 1'b0, 1'b0, "rb_after");

      $display("[TB] randomized cycles");
      for (int i = 0; i < 600; i++) begin
         r = int'($urandom_range(0, 15));
         if (r < 2)
            dxR = mkR(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'b00110);
         else if (r < 4)
            dxR = mkR(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'b00111);
         else if (r < 9)
            dxR = mkLw(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         else if (r < 14)
            dxR = mkR(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 5)));
         else
            dxR = $urandom();
         if ($urandom_range(0, 7) == 0)
            fdR = $urandom();
         else
            fdR = mkR(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'd0);
         applyStimulus(fdR, dxR, ($urandom_range(0, 5) == 0), ($urandom_range(0, 19) == 0), "random");
      end

`ifdef HAZARD_PERF_EN
      checkVal("perf_stall_cnt", int'(stallCnt), stallM);
      checkVal("perf_flush_cnt", int'(flushCnt), flushM);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
      $finish;
   end

endmodule
